scm_1w64b_1r32b_ctrl: RTL
=========================

Name: scm_1w64b_1r32b_ctrl

Overview:
- Controller in front of the latch-SCM register file with a 64b write port and a 32b read port.
- Arbitrates N_RD 32b read requesters round-robin onto the single read port.
- Accepts 64b writes with per-half enables; half writes become read-modify-write by borrowing the read port for one cycle.
- Prevents same-cycle read/write to the same row, so requesters never see a torn row.

Parameters:
N_RD, 2, number of read requesters (>=1)
WADDR_WIDTH, 5, row address width; rows = 2**WADDR_WIDTH
RADDR_WIDTH, WADDR_WIDTH+1, 32b word address; bit0 selects half (0=lo [31:0], 1=hi [63:32])

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rd_req_i  in  N_RD  read request per requester
rd_addr_i  in  N_RD*RADDR_WIDTH  word address per requester, requester k at slice k
rd_gnt_o  out  N_RD  one-hot grant, same cycle as request
rd_rvalid_o  out  N_RD  one-hot response valid, one cycle after grant
rd_rdata_o  out  32  response data, shared by all requesters
wr_req_i  in  1  write request
wr_be_i  in  2  half enables: bit0=lo, bit1=hi
wr_addr_i  in  WADDR_WIDTH  row address
wr_data_i  in  64  write data
wr_gnt_o  out  1  write accepted
rf_read_enable_o  out  1  to RF ReadEnable
rf_read_addr_o  out  RADDR_WIDTH  to RF ReadAddr
rf_read_data_i  in  32  from RF ReadData, valid the cycle after the read
rf_write_enable_o  out  1  to RF WriteEnable
rf_write_addr_o  out  WADDR_WIDTH  to RF WriteAddr
rf_write_data_o  out  64  to RF WriteData
busy_o  out  1  high while FSM is not IDLE

Behaviour:
- Reset (sync, rst=1):
  - State=IDLE and round-robin pointer=0.
  - Registered rvalid/id and RMW capture registers cleared.
  - All grant, valid and RF-enable outputs are 0.
  - rd_rdata_o follows rf_read_data_i, unqualified.
- FSM states and transitions:
  - IDLE:
    - wr_req_i & be==11: rf_write_enable_o=1 same cycle with wr_addr_i/wr_data_i; wr_gnt_o=1; stay in IDLE.
    - wr_req_i & be==00: wr_gnt_o=1; no RF write.
    - wr_req_i & be==01 or 10: wr_gnt_o=1; latch addr, data and be; go to RMW_RD.
  - RMW_RD:
    - Drive rf_read_enable_o=1 with rf_read_addr_o={row, be==01}, i.e. the untouched half.
    - No user read grant; wr_gnt_o=0; go to RMW_WR.
  - RMW_WR:
    - Merge rf_read_data_i into the untouched half and the latched data into the written half.
    - rf_write_enable_o=1; wr_gnt_o=0; go to IDLE.
- Read arbitration (IDLE and RMW_WR):
  - Eligible requester: rd_req_i[k]=1 and, if an RF write is issued this cycle, rd_addr_i[k][RADDR_WIDTH-1:1] != write row.
  - Round-robin: search starts at the pointer; at most one grant per cycle.
  - After a grant to k, pointer = (k+1) mod N_RD; no grant leaves the pointer unchanged.
  - The granted address drives rf_read_addr_o with rf_read_enable_o=1.
- Read latency is exactly 1:
  - rd_rvalid_o[k]=1 in the cycle after rd_gnt_o[k].
  - rd_rdata_o = rf_read_data_i (the RF registers the half select internally).
  - No response is produced for the RMW internal read.
- Requester protocol: a requester holds req/addr until granted; the controller holds no read requests internally.
- Write protocol: hold wr_req_i until granted; wr_gnt_o is combinational from state and wr_req_i.
- A write issued in cycle t is visible to reads granted at t+1 or later.
- Reset in RMW_RD or RMW_WR aborts the operation:
  - No RF write in the reset cycle.
  - The granted half write is lost by design.

Decomposition:
- Package scm_ctrl_pkg:
  - ctrl_state_e {IDLE, RMW_RD, RMW_WR}.
  - BE_NONE=2'b00, BE_LO=2'b01, BE_HI=2'b10, BE_FULL=2'b11.
- Sub-module scm_rr_arbiter:
  - Parameter N.
  - Inputs: req, mask, advance.
  - Outputs: one-hot gnt, registered pointer.
  - Reuse target for other SCM controllers.

Test Plan:
- Full write and both halves: full write row 3 = 0x1111_2222_3333_4444, then read addr 6 → rdata 0x3333_4444 with rvalid one cycle after gnt; read addr 7 → 0x1111_2222.
- Lo-half write: preload row 5 = 0xAAAA_BBBB_CCCC_DDDD, write be=01 lo=0x1234_5678 → RF read of addr 11 in RMW_RD, RF write of 0xAAAA_BBBB_1234_5678 in RMW_WR; busy_o high for 2 cycles; a second write request is not granted during those 2 cycles.
- Round-robin fairness: N_RD=2, both requesters request continuously for 6 cycles → grants 0,1,0,1,0,1; rvalid mirrors the grants delayed one cycle.
- Port stealing: requester 0 requests in the cycle the FSM enters RMW_RD → no grant that cycle; granted in RMW_WR; response correct.
- Same-row conflict: full write row 2 = X while requester 1 reads addr 4 in the same cycle → no grant; granted the next cycle; rdata = X[31:0].
- Reset mid-RMW: rst=1 while in RMW_RD → no RF write; busy_o=0, all grants and rvalid 0 the next cycle; row content unchanged.

Source files
------------

// File: rtl/scm_ctrl_pkg.sv
// Shared types and constants for the SCM register-file controllers.
package scm_ctrl_pkg;

   // Controller FSM: idle, borrow the read port, then write the merged row.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_RD = 2'd1,
      RMW_WR = 2'd2
   } ctrl_state_e;

   // Write half enables: bit0 = lo [31:0], bit1 = hi [63:32].
   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_FULL = 2'b11;

endpackage

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req_i & mask_i, searching from
// the registered pointer; the pointer moves past the winner on each grant.
module scm_rr_arbiter #(
   parameter int N = 2,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     mask_i,
   input  logic             advance_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] ptr_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [N-1:0]     eligible;
   logic             found;
   int               idx;

   assign eligible = req_i & mask_i;
   assign ptr_o    = ptr_q;

   // Pick the first eligible requester at or after the pointer.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves a value held, which would infer a latch.
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      if (advance_i) begin
         for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
               gnt_o[idx] = 1'b1;
               found      = 1'b1;
               ptr_d      = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/scm_1w64b_1r32b_ctrl.sv
// Controller for a latch SCM with one 64b write port and one 32b read port.
// Arbitrates read requesters round-robin, turns half writes into a
// read-modify-write by borrowing the read port, and never reads a row in the
// cycle it is being written.
module scm_1w64b_1r32b_ctrl
   import scm_ctrl_pkg::*;
#(
   parameter int N_RD        = 2,
   parameter int WADDR_WIDTH = 5,
   parameter int RADDR_WIDTH = WADDR_WIDTH + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_RD-1:0]               rd_req_i,
   input  logic [N_RD*RADDR_WIDTH-1:0]   rd_addr_i,
   output logic [N_RD-1:0]               rd_gnt_o,
   output logic [N_RD-1:0]               rd_rvalid_o,
   output logic [31:0]                   rd_rdata_o,
   input  logic                          wr_req_i,
   input  logic [1:0]                    wr_be_i,
   input  logic [WADDR_WIDTH-1:0]        wr_addr_i,
   input  logic [63:0]                   wr_data_i,
   output logic                          wr_gnt_o,
   output logic                          rf_read_enable_o,
   output logic [RADDR_WIDTH-1:0]        rf_read_addr_o,
   input  logic [31:0]                   rf_read_data_i,
   output logic                          rf_write_enable_o,
   output logic [WADDR_WIDTH-1:0]        rf_write_addr_o,
   output logic [63:0]                   rf_write_data_o,
   output logic                          busy_o
);

   localparam int PTR_W = (N_RD > 1) ? $clog2(N_RD) : 1;

   ctrl_state_e            state_q, state_d;
   logic [WADDR_WIDTH-1:0] addr_q, addr_d;
   logic [63:0]            data_q, data_d;
   logic [1:0]             be_q, be_d;
   logic [N_RD-1:0]        rvalid_q;
   logic                   rmw_rd;
   logic [N_RD-1:0]        arb_mask;
   logic [N_RD-1:0]        arb_gnt;
   logic                   arb_advance;
   logic [PTR_W-1:0]       arb_ptr_unused;

   // FSM next state and write-port drive; reset suppresses every enable.
   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      data_d            = data_q;
      be_d              = be_q;
      wr_gnt_o          = 1'b0;
      rmw_rd            = 1'b0;
      rf_write_enable_o = 1'b0;
      rf_write_addr_o   = wr_addr_i;
      rf_write_data_o   = wr_data_i;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (wr_req_i) begin
                  wr_gnt_o = 1'b1;
                  case (wr_be_i)
                     BE_FULL: rf_write_enable_o = 1'b1;
                     BE_LO, BE_HI: begin
                        addr_d  = wr_addr_i;
                        data_d  = wr_data_i;
                        be_d    = wr_be_i;
                        state_d = RMW_RD;
                     end
                     default: ;
                  endcase
               end
            end
            RMW_RD: begin
               rmw_rd  = 1'b1;
               state_d = RMW_WR;
            end
            RMW_WR: begin
               rf_write_enable_o = 1'b1;
               rf_write_addr_o   = addr_q;
               rf_write_data_o   = (be_q == BE_LO) ? {rf_read_data_i, data_q[31:0]}
                                                   : {data_q[63:32], rf_read_data_i};
               state_d           = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Hide requesters targeting the row being written this cycle.
   always_comb begin
      arb_mask = '1;
      for (int k = 0; k < N_RD; k++) begin
         arb_mask[k] = !(rf_write_enable_o &&
                         (rd_addr_i[k*RADDR_WIDTH+1 +: WADDR_WIDTH] == rf_write_addr_o));
      end
   end

   assign arb_advance = !rst && (state_q != RMW_RD);

   scm_rr_arbiter #(.N(N_RD)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (rd_req_i),
      .mask_i    (arb_mask),
      .advance_i (arb_advance),
      .gnt_o     (arb_gnt),
      .ptr_o     (arb_ptr_unused)
   );

   // Read port: the RMW fetch of the untouched half, else the granted requester.
   always_comb begin
      rf_read_enable_o = 1'b0;
      rf_read_addr_o   = {addr_q, be_q == BE_LO};
      if (rmw_rd) begin
         rf_read_enable_o = 1'b1;
      end else begin
         for (int k = 0; k < N_RD; k++) begin
            if (arb_gnt[k]) begin
               rf_read_enable_o = 1'b1;
               rf_read_addr_o   = rd_addr_i[k*RADDR_WIDTH +: RADDR_WIDTH];
            end
         end
      end
   end

   // State, capture registers and one-cycle-delayed response valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         // NOTE: the capture registers are reset too, so the RMW path never starts from X data.
         data_q   <= '0;
         be_q     <= BE_NONE;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         be_q     <= be_d;
         rvalid_q <= arb_gnt;
      end
   end

   assign rd_gnt_o    = arb_gnt;
   assign rd_rvalid_o = rst ? '0 : rvalid_q;
   assign rd_rdata_o  = rf_read_data_i;
   assign busy_o      = (state_q != IDLE);

endmodule
